// File: rtl/seg7_pkg.sv
// Shared glyph constants and helpers for the multiplexed seven-segment driver.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Ceiling log2 with a floor of 1 so single-entry counters still get a bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 1;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

    // Active-low {g,f,e,d,c,b,a} glyphs for 0-F.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (n)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, DATA_W cycles per value.
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Start,
    input  logic [DATA_W-1:0]       Bin,
    output logic                    Busy,
    output logic                    Done,
    output logic [4*NUM_DIGITS-1:0] Bcd,
    output logic                    Ovf
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = clog2(DATA_W);

    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [DATA_W-1:0] bin_q,  bin_d;
    logic [BCD_W-1:0]  bcd_q,  bcd_d;
    logic              ovf_q,  ovf_d;

    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W:0]    shifted;
    logic              last;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            bin_q  <= '0;
            bcd_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            bin_q  <= bin_d;
            bcd_q  <= bcd_d;
            ovf_q  <= ovf_d;
        end
    end

    // Add-3 on every digit >= 5, then shift in the next binary MSB; the bit
    // falling off the top digit marks an unrepresentable value.
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        shifted = {bcd_adj, bin_q[DATA_W-1]};
        last    = (cnt_q == CNT_W'(DATA_W - 1));

        if (!busy_q) begin
            if (Start) begin
                busy_d = 1'b1;
                cnt_d  = '0;
                bin_d  = Bin;
                bcd_d  = '0;
                ovf_d  = 1'b0;
            end
        end else begin
            bcd_d = shifted[BCD_W-1:0];
            bin_d = bin_q << 1;
            ovf_d = ovf_q | shifted[BCD_W];
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    // Result is presented combinationally on the final cycle so the consumer
    // can latch it on the same edge that ends Busy.
    assign Busy = busy_q;
    assign Done = busy_q & last;
    assign Bcd  = shifted[BCD_W-1:0];
    assign Ovf  = ovf_q | shifted[BCD_W];

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed seven-segment driver: hex or decimal value, leading-zero blanking,
// per-digit decimal points, overflow dashes and programmable scan rate.
module seg7_scan_display
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SCAN_DIV   = 100000
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Load,
    input  logic [DATA_W-1:0]     Value,
    input  logic                  DecMode,
    input  logic                  BlankZeros,
    input  logic [NUM_DIGITS-1:0] DpMask,
    output logic                  Busy,
    output logic [6:0]            out7,
    output logic                  dp_out,
    output logic [NUM_DIGITS-1:0] en_out
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W = clog2(NUM_DIGITS);
    localparam int unsigned PSC_W = clog2(SCAN_DIV);

    logic [PSC_W-1:0]      psc_q,  psc_d;
    logic [IDX_W-1:0]      idx_q,  idx_d;
    logic [BCD_W-1:0]      disp_q, disp_d;
    logic                  ovf_q,  ovf_d;
    logic [6:0]            seg_q,  seg_d;
    logic                  dp_q,   dp_d;
    logic [NUM_DIGITS-1:0] en_q,   en_d;

    logic                  conv_busy;
    logic                  conv_done;
    logic [BCD_W-1:0]      conv_bcd;
    logic                  conv_ovf;
    logic                  dec_start;
    logic                  hex_load;
    logic [BCD_W-1:0]      upper;
    logic [3:0]            digit;

    assign dec_start = Load & DecMode & ~conv_busy;
    assign hex_load  = Load & ~DecMode & ~conv_busy;

    bin2bcd_seq #(
        .DATA_W    (DATA_W),
        .NUM_DIGITS(NUM_DIGITS)
    ) u_bin2bcd (
        .Clk  (Clk),
        .Rst  (Rst),
        .Start(dec_start),
        .Bin  (Value),
        .Busy (conv_busy),
        .Done (conv_done),
        .Bcd  (conv_bcd),
        .Ovf  (conv_ovf)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            psc_q  <= '0;
            idx_q  <= '0;
            disp_q <= '0;
            ovf_q  <= 1'b0;
            seg_q  <= SEG_BLANK;
            dp_q   <= 1'b1;
            en_q   <= '1;
        end else begin
            psc_q  <= psc_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            ovf_q  <= ovf_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            en_q   <= en_d;
        end
    end

    always_comb begin
        psc_d  = psc_q + PSC_W'(1);
        idx_d  = idx_q;
        disp_d = disp_q;
        ovf_d  = ovf_q;

        if (psc_q == PSC_W'(SCAN_DIV - 1)) begin
            psc_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        if (hex_load) begin
            disp_d = BCD_W'(Value);
            ovf_d  = 1'b0;
        end else if (conv_done) begin
            disp_d = conv_bcd;
            ovf_d  = conv_ovf;
        end
    end

    // Current digit and everything above it; all-zero upper part means a leading zero.
    always_comb begin
        upper = disp_q >> {idx_q, 2'b00};
        digit = 4'(upper);
        seg_d = hex_to_seg(digit);
        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (BlankZeros && (idx_q != '0) && (upper == '0)) begin
            seg_d = SEG_BLANK;
        end
        dp_d = ~1'(DpMask >> idx_q);
        en_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    assign Busy   = conv_busy;
    assign out7   = seg_q;
    assign dp_out = dp_q;
    assign en_out = en_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with 8 digits, 32-bit value, 4-cycle scan.
module tb_seg7_scan_display;

    localparam int unsigned N  = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned SD = 4;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G2 = 7'b0100100;
    localparam logic [6:0] G4 = 7'b0011001;
    localparam logic [6:0] G5 = 7'b0010010;
    localparam logic [6:0] G9 = 7'b0010000;
    localparam logic [6:0] GB = 7'b1111111;
    localparam logic [6:0] GD = 7'b0111111;

    logic          clk;
    logic          rst_n;
    logic          load;
    logic [DW-1:0] value;
    logic          dec_mode;
    logic          blank_zeros;
    logic [N-1:0]  dp_mask;
    logic          busy;
    logic [6:0]    out7;
    logic          dp_out;
    logic [N-1:0]  en_out;

    int checks = 0;
    int errors = 0;

    // Glyphs of 32'h1234ABCD, digit 0 first: D C b A 4 3 2 1
    logic [6:0] hexg [8] = '{7'b0100001, 7'b1000110, 7'b0000011, 7'b0001000,
                             7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    seg7_scan_display #(
        .NUM_DIGITS(N),
        .DATA_W    (DW),
        .SCAN_DIV  (SD)
    ) dut (
        .Clk       (clk),
        .Rst       (rst_n),
        .Load      (load),
        .Value     (value),
        .DecMode   (dec_mode),
        .BlankZeros(blank_zeros),
        .DpMask    (dp_mask),
        .Busy      (busy),
        .out7      (out7),
        .dp_out    (dp_out),
        .en_out    (en_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_load(input logic [DW-1:0] v, input logic dec);
        load = 1'b1; value = v; dec_mode = dec;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_digit(input string tag, input int i, input logic [6:0] seg, input logic dp);
        logic [N-1:0] want;
        int n;
        want = ~(N'(1) << i);
        n = 0;
        while (en_out !== want && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s_d%0d_en", tag, i), 32'(en_out), 32'(want));
        chk($sformatf("%s_d%0d_seg", tag, i), 32'(out7), 32'(seg));
        chk($sformatf("%s_d%0d_dp", tag, i), 32'(dp_out), 32'(dp));
    endtask

    initial begin
        int n;
        int idx;
        logic [N-1:0] e;

        rst_n = 1'b0; load = 1'b0; value = '0; dec_mode = 1'b0;
        blank_zeros = 1'b0; dp_mask = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out7", 32'(out7), 32'h7F);
        chk("rst_dp", 32'(dp_out), 32'd1);
        chk("rst_en", 32'(en_out), 32'hFF);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_en", 32'(en_out), 32'hFE);
        chk("first_seg", 32'(out7), 32'(G0));
        chk("first_dp", 32'(dp_out), 32'd1);

        // Hex scan of 32'h1234ABCD
        pulse_load(32'h1234ABCD, 1'b0);
        chk("hex_busy", 32'(busy), 32'd0);
        n = 0;
        while (en_out !== 8'h7F && n < 40) begin @(negedge clk); n++; end
        chk("sync_7f", 32'(en_out), 32'h7F);
        n = 0;
        while (en_out !== 8'hFE && n < 10) begin @(negedge clk); n++; end
        chk("sync_fe", 32'(en_out), 32'hFE);
        for (int k = 0; k < 32; k++) begin
            e = ~(N'(1) << (k / 4));
            chk($sformatf("scan%0d_en", k), 32'(en_out), 32'(e));
            chk($sformatf("scan%0d_seg", k), 32'(out7), 32'(hexg[k / 4]));
            chk($sformatf("scan%0d_busy", k), 32'(busy), 32'd0);
            @(negedge clk);
        end

        // Decimal 255 with blanking; old value stays on display while busy
        blank_zeros = 1'b1;
        pulse_load(32'd255, 1'b1);
        chk("dec_busy_rise", 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            idx = 0;
            for (int j = 0; j < int'(N); j++) if (en_out[j] == 1'b0) idx = j;
            chk($sformatf("dec_hold%0d", n), 32'(out7), 32'(hexg[idx]));
            n++;
            @(negedge clk);
        end
        chk("dec_busy_len", 32'(n), 32'd32);
        @(negedge clk);
        check_digit("d255", 0, G5, 1'b1);
        check_digit("d255", 1, G5, 1'b1);
        check_digit("d255", 2, G2, 1'b1);
        for (int i = 3; i < int'(N); i++) check_digit("d255", i, GB, 1'b1);

        // Decimal points follow DpMask even on a blanked digit
        dp_mask = 8'b00000100;
        pulse_load(32'h0, 1'b0);
        @(negedge clk);
        check_digit("dp", 0, G0, 1'b1);
        for (int i = 1; i < int'(N); i++) check_digit("dp", i, GB, (i == 2) ? 1'b0 : 1'b1);

        // Largest representable decimal value
        pulse_load(32'd99999999, 1'b1);
        wait_idle("max");
        for (int i = 0; i < int'(N); i++) check_digit("max", i, G9, (i == 2) ? 1'b0 : 1'b1);

        // Overflow shows dashes; hex load clears it
        pulse_load(32'd100000000, 1'b1);
        wait_idle("ovf");
        for (int i = 0; i < int'(N); i++) check_digit("ovf", i, GD, (i == 2) ? 1'b0 : 1'b1);
        pulse_load(32'h0, 1'b0);
        @(negedge clk);
        check_digit("ovfclr", 0, G0, 1'b1);
        check_digit("ovfclr", 1, GB, 1'b1);

        // Load during busy is ignored
        pulse_load(32'd42, 1'b1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (n == 5) begin load = 1'b1; value = 32'd7; dec_mode = 1'b1; end
            else load = 1'b0;
            @(negedge clk);
        end
        load = 1'b0;
        chk("ign_busy_len", 32'(n), 32'd32);
        @(negedge clk);
        check_digit("d42", 0, G2, 1'b1);
        check_digit("d42", 1, G4, 1'b1);
        for (int i = 2; i < int'(N); i++) check_digit("d42", i, GB, (i == 2) ? 1'b0 : 1'b1);

        // Reset in the middle of a conversion
        pulse_load(32'd12345, 1'b1);
        repeat (9) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_en", 32'(en_out), 32'hFF);
        chk("mrst_out7", 32'(out7), 32'h7F);
        chk("mrst_dp", 32'(dp_out), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrel_en", 32'(en_out), 32'hFE);
        chk("mrel_seg", 32'(out7), 32'(G0));
        chk("mrel_busy", 32'(busy), 32'd0);
        for (int i = 1; i < int'(N); i++) check_digit("mrel", i, GB, (i == 2) ? 1'b0 : 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
